instr_fetch_unit: RTL and testbench



---
 rtl/instr_fetch_unit.sv | 126 ++++++++++++
 tb/tb_instr_fetch_unit.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage for the 16-bit core.
// Keeps the PC, issues credit-limited requests to instruction memory, and
// queues in-order responses (tagged with their fetch address) for decode.
// A redirect reloads the PC, flushes the queue and drops any response still
// in flight for the old instruction stream.
module instr_fetch_unit #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [15:0] imem_rdata,
    input  logic        redir_valid,
    input  logic [15:0] redir_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [15:0] instr,
    output logic [15:0] instr_pc,
    output logic [4:0]  opcode
);

    // Counters are 3 bits wide: DEPTH never exceeds 4.
    localparam logic [2:0] DEPTH_C = 3'(DEPTH);

    logic [15:0] pc;
    logic [2:0]  fifo_cnt;
    logic [2:0]  out_cnt;
    logic [2:0]  drop_cnt;

    logic [15:0] aq       [DEPTH];
    logic [15:0] fifo_ins [DEPTH];
    logic [15:0] fifo_adr [DEPTH];

    logic        gnt;
    logic        rsp;
    logic        rsp_keep;
    logic        pop;
    logic [3:0]  credit_used;
    logic [2:0]  aq_wr;
    logic [2:0]  fifo_wr;

    assign imem_addr = pc;

    // Handshake qualification, credit check and head-of-queue presentation.
    always_comb begin
        credit_used = {1'b0, fifo_cnt} + {1'b0, out_cnt};
        imem_req    = !rst && !redir_valid && (credit_used < {1'b0, DEPTH_C});
        gnt         = imem_req && imem_gnt;
        // A response with nothing outstanding is stale (e.g. from before reset).
        rsp         = imem_rvalid && (out_cnt != 3'd0);
        // Same-cycle redirect means this response belongs to the old stream.
        rsp_keep    = rsp && (drop_cnt == 3'd0) && !redir_valid;
        instr_valid = !rst && (fifo_cnt != 3'd0);
        pop         = instr_valid && instr_ready;
        aq_wr       = rsp ? (out_cnt - 3'd1) : out_cnt;
        fifo_wr     = pop ? (fifo_cnt - 3'd1) : fifo_cnt;
        instr       = (fifo_cnt != 3'd0) ? fifo_ins[0] : 16'h0000;
        instr_pc    = (fifo_cnt != 3'd0) ? fifo_adr[0] : 16'h0000;
        opcode      = instr[15:11];
    end

    // PC, outstanding-request, drop and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc       <= RESET_PC;
            out_cnt  <= 3'd0;
            drop_cnt <= 3'd0;
            fifo_cnt <= 3'd0;
        end else begin
            if (redir_valid) begin
                pc <= redir_pc & 16'hFFFE;
            end else if (gnt) begin
                pc <= pc + 16'd2;
            end

            out_cnt <= out_cnt + {2'b00, gnt} - {2'b00, rsp};

            // Every request still in flight after a redirect belongs to the
            // old stream, so the drop count becomes whatever remains
            // outstanding; this stays exact across back-to-back redirects.
            if (redir_valid) begin
                drop_cnt <= out_cnt - {2'b00, rsp};
            end else if (rsp && (drop_cnt != 3'd0)) begin
                drop_cnt <= drop_cnt - 3'd1;
            end

            if (redir_valid) begin
                fifo_cnt <= 3'd0;
            end else begin
                fifo_cnt <= fifo_cnt + {2'b00, rsp_keep} - {2'b00, pop};
            end
        end
    end

    // Both queues keep their head at index 0: entries shift down on pop and a
    // new entry lands just past the surviving tail. Contents need no reset
    // because the counts qualify them.
    for (genvar i = 0; i < DEPTH; i++) begin : g_q
        localparam int NX = (i < DEPTH - 1) ? i + 1 : i;

        // Address queue: push the granted PC, pop on each counted response.
        always_ff @(posedge clk) begin
            if (gnt && (aq_wr == 3'(i))) begin
                aq[i] <= pc;
            end else if (rsp) begin
                aq[i] <= aq[NX];
            end
        end

        // Prefetch FIFO: push kept responses with their address, pop to decode.
        always_ff @(posedge clk) begin
            if (rsp_keep && (fifo_wr == 3'(i))) begin
                fifo_ins[i] <= imem_rdata;
                fifo_adr[i] <= aq[0];
            end else if (pop) begin
                fifo_ins[i] <= fifo_ins[NX];
                fifo_adr[i] <= fifo_adr[NX];
            end
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a small in-order memory responder.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid = 1'b0;
    logic [15:0] imem_rdata  = 16'h0000;
    logic        redir_valid;
    logic [15:0] redir_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] instr;
    logic [15:0] instr_pc;
    logic [4:0]  opcode;

    int n_chk = 0;
    int n_err = 0;

    bit rsp_en = 1'b0;
    bit stray  = 1'b0;
    bit from_q = 1'b0;

    logic [15:0] pend_q  [$];
    logic [15:0] gnt_log [$];
    logic [15:0] acc_pc  [$];
    logic [15:0] acc_ins [$];
    logic [4:0]  acc_op  [$];

    always #5 clk = ~clk;

    instr_fetch_unit #(.RESET_PC(16'h0000), .DEPTH(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .redir_valid (redir_valid),
        .redir_pc    (redir_pc),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .opcode      (opcode)
    );

    function automatic logic [15:0] mem(input logic [15:0] a);
        return (a == 16'h0000) ? 16'hF801 : (a ^ 16'hC3A5);
    endfunction

    // Memory responds one cycle after each grant; also logs grants and decode pops.
    always @(posedge clk) begin
        if (imem_rvalid && from_q) void'(pend_q.pop_front());
        if (imem_req && imem_gnt) begin
            pend_q.push_back(imem_addr);
            gnt_log.push_back(imem_addr);
        end
        if (instr_valid && instr_ready) begin
            acc_pc.push_back(instr_pc);
            acc_ins.push_back(instr);
            acc_op.push_back(opcode);
        end
        #1;
        from_q      = rsp_en && (pend_q.size() != 0);
        imem_rvalid = from_q || stray;
        imem_rdata  = from_q ? mem(pend_q[0]) : (stray ? 16'hDEAD : 16'h0000);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clr();
        gnt_log.delete();
        acc_pc.delete();
        acc_ins.delete();
        acc_op.delete();
    endtask

    task automatic redirect(input logic [15:0] tgt);
        redir_valid = 1'b1;
        redir_pc    = tgt;
        @(negedge clk);
        redir_valid = 1'b0;
    endtask

    task automatic quiesce();
        int k = 0;
        imem_gnt    = 1'b0;
        instr_ready = 1'b1;
        rsp_en      = 1'b1;
        stray       = 1'b0;
        while (k < 30 && (pend_q.size() != 0 || imem_rvalid || instr_valid)) begin
            @(negedge clk);
            k++;
        end
        check("quiesce_busy", 32'(pend_q.size() != 0 || imem_rvalid || instr_valid), 32'd0);
        clr();
    endtask

    task automatic wait_acc(input int n, input int budget);
        int k = 0;
        while (acc_pc.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        check("acc_count", 32'(acc_pc.size() >= n), 32'd1);
    endtask

    task automatic wait_gnt(input int n, input int budget);
        int k = 0;
        while (gnt_log.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        check("gnt_count", 32'(gnt_log.size()), 32'(n));
    endtask

    // Waits for one head entry in the FIFO plus a response on the bus.
    task automatic wait_busy(input string tag);
        int k = 0;
        while (k < 10 && !(instr_valid && imem_rvalid)) begin
            @(negedge clk);
            k++;
        end
        check(tag, 32'(instr_valid && imem_rvalid), 32'd1);
    endtask

    initial begin
        logic [15:0] w;
        rst         = 1'b1;
        imem_gnt    = 1'b0;
        redir_valid = 1'b0;
        redir_pc    = 16'h0000;
        instr_ready = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_req",   imem_req,    1'b0);
        check("rst_valid", instr_valid, 1'b0);
        check("rst_instr", instr,       16'h0000);
        check("rst_ipc",   instr_pc,    16'h0000);
        check("rst_addr",  imem_addr,   16'h0000);

        // Streaming fetch from reset PC with latency check
        rst = 1'b0; imem_gnt = 1'b1; rsp_en = 1'b1; instr_ready = 1'b1;
        #1;
        check("t1_req",  imem_req,  1'b1);
        check("t1_addr", imem_addr, 16'h0000);
        @(negedge clk);
        check("t1_lat1",  instr_valid, 1'b0);
        check("t1_addr2", imem_addr,   16'h0002);
        @(negedge clk);
        check("t1_lat2",  instr_valid, 1'b1);
        check("t1_instr", instr,       16'hF801);
        check("t1_op",    opcode,      5'h1F);
        check("t1_ipc",   instr_pc,    16'h0000);
        wait_acc(4, 40);
        for (int i = 0; i < 4; i++) begin
            w = mem(16'(2 * i));
            check("t1_gnt", gnt_log[i], 32'(2 * i));
            check("t1_pc",  acc_pc[i],  32'(2 * i));
            check("t1_ins", acc_ins[i], w);
            check("t1_opc", acc_op[i],  w[15:11]);
        end

        // Credit limit with decode stalled, then resume
        quiesce();
        instr_ready = 1'b0;
        redirect(16'h0000);
        check("t2_addr", imem_addr, 16'h0000);
        clr();
        imem_gnt = 1'b1;
        repeat (8) @(negedge clk);
        check("t2_ngnt",  gnt_log.size(), 32'd2);
        check("t2_gnt0",  gnt_log[0],     16'h0000);
        check("t2_gnt1",  gnt_log[1],     16'h0002);
        check("t2_req",   imem_req,       1'b0);
        check("t2_valid", instr_valid,    1'b1);
        check("t2_ipc",   instr_pc,       16'h0000);
        check("t2_instr", instr,          16'hF801);
        repeat (3) @(negedge clk);
        check("t2_hold_ipc", instr_pc, 16'h0000);
        check("t2_hold_op",  opcode,   5'h1F);
        instr_ready = 1'b1;
        wait_acc(3, 30);
        check("t2_pc0",  acc_pc[0],  16'h0000);
        check("t2_pc1",  acc_pc[1],  16'h0002);
        check("t2_pc2",  acc_pc[2],  16'h0004);
        check("t2_gnt2", gnt_log[2], 16'h0004);

        // Redirect with two requests outstanding
        quiesce();
        redirect(16'h0010);
        rsp_en = 1'b0; imem_gnt = 1'b1; instr_ready = 1'b1;
        wait_gnt(2, 10);
        check("t3_gnt0",     gnt_log[0], 16'h0010);
        check("t3_gnt1",     gnt_log[1], 16'h0012);
        check("t3_req_full", imem_req,   1'b0);
        redir_valid = 1'b1; redir_pc = 16'h0101;
        #1;
        check("t3_req_redir", imem_req, 1'b0);
        @(negedge clk);
        redir_valid = 1'b0; rsp_en = 1'b1;
        check("t3_addr", imem_addr, 16'h0100);
        wait_acc(1, 20);
        check("t3_pc",     acc_pc[0],  16'h0100);
        check("t3_ins",    acc_ins[0], mem(16'h0100));
        check("t3_newgnt", gnt_log[2], 16'h0100);

        // Redirect together with a response and a decode pop
        quiesce();
        redirect(16'h0040);
        instr_ready = 1'b0; rsp_en = 1'b1; imem_gnt = 1'b1;
        wait_busy("t4_setup");
        check("t4_head", instr_pc, 16'h0040);
        instr_ready = 1'b1; redir_valid = 1'b1; redir_pc = 16'h0200;
        @(negedge clk);
        redir_valid = 1'b0;
        check("t4_flush", instr_valid,   1'b0);
        check("t4_nacc",  acc_pc.size(), 32'd1);
        check("t4_pop",   acc_pc[0],     16'h0040);
        check("t4_addr",  imem_addr,     16'h0200);
        wait_acc(2, 20);
        check("t4_pc",  acc_pc[1],  16'h0200);
        check("t4_ins", acc_ins[1], mem(16'h0200));

        // Redirect with a same-cycle response and one more still in flight
        quiesce();
        redirect(16'h0300);
        rsp_en = 1'b0; imem_gnt = 1'b1; instr_ready = 1'b1;
        wait_gnt(2, 10);
        rsp_en = 1'b1;
        @(negedge clk);
        check("t5_rv", imem_rvalid, 1'b1);
        redir_valid = 1'b1; redir_pc = 16'h0400;
        @(negedge clk);
        redir_valid = 1'b0;
        check("t5_flush", instr_valid, 1'b0);
        wait_acc(1, 20);
        check("t5_pc",  acc_pc[0],  16'h0400);
        check("t5_ins", acc_ins[0], mem(16'h0400));

        // PC wrap
        quiesce();
        redirect(16'hFFFE);
        rsp_en = 1'b1; imem_gnt = 1'b1; instr_ready = 1'b1;
        wait_acc(2, 20);
        check("t6_gnt0", gnt_log[0], 16'hFFFE);
        check("t6_gnt1", gnt_log[1], 16'h0000);
        check("t6_pc0",  acc_pc[0],  16'hFFFE);
        check("t6_pc1",  acc_pc[1],  16'h0000);
        check("t6_ins1", acc_ins[1], 16'hF801);

        // Back-to-back redirects: last target wins
        quiesce();
        redir_valid = 1'b1; redir_pc = 16'h0500;
        @(negedge clk);
        redir_pc = 16'h0600;
        @(negedge clk);
        redir_valid = 1'b0;
        check("t7_addr", imem_addr, 16'h0600);
        imem_gnt = 1'b1;
        wait_acc(1, 20);
        check("t7_pc", acc_pc[0], 16'h0600);

        // Reset mid-operation, stray response afterwards, restart
        quiesce();
        redirect(16'h0080);
        instr_ready = 1'b0; rsp_en = 1'b1; imem_gnt = 1'b1;
        wait_busy("t8_setup");
        rst = 1'b1; rsp_en = 1'b0; imem_gnt = 1'b0;
        #1;
        check("t8_req_rst",   imem_req,    1'b0);
        check("t8_valid_rst", instr_valid, 1'b0);
        @(negedge clk);
        check("t8_valid", instr_valid, 1'b0);
        check("t8_pc",    imem_addr,   16'h0000);
        check("t8_instr", instr,       16'h0000);
        rst = 1'b0; stray = 1'b1;
        @(negedge clk);
        check("t8_stray_on", imem_rvalid, 1'b1);
        stray = 1'b0;
        @(negedge clk);
        check("t8_stray_valid", instr_valid, 1'b0);
        check("t8_stray_req",   imem_req,    1'b1);
        check("t8_stray_pc",    imem_addr,   16'h0000);
        clr();
        imem_gnt = 1'b1; rsp_en = 1'b1; instr_ready = 1'b1;
        wait_acc(2, 20);
        check("t8_pc0",  acc_pc[0],  16'h0000);
        check("t8_pc1",  acc_pc[1],  16'h0002);
        check("t8_ins0", acc_ins[0], 16'hF801);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
